// File: rtl/shiftrows_pipe.sv
// Rijndael ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns, followed by an elastic
// valid/ready register pipeline of STAGES entries that carries the mode tag with each block.
module shiftrows_pipe #(
    parameter int unsigned NB     = 4,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [32*NB-1:0] i_block,
    input  logic             i_inv,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [32*NB-1:0] o_block,
    output logic             o_inv
);

    localparam int unsigned W = 32 * NB;

    // Rijndael uses offsets 0,1,3,4 for 256-bit blocks; 0,1,2,3 otherwise.
    function automatic int unsigned row_shift(input int unsigned r);
        unique case (r)
            0:       return 0;
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            default: return (NB == 8) ? 4 : 3;
        endcase
    endfunction

    function automatic int unsigned src_col(input int unsigned c, input int unsigned r,
                                            input logic inv);
        if (inv) begin
            return (c + NB - row_shift(r)) % NB;
        end
        return (c + row_shift(r)) % NB;
    endfunction

    logic [W-1:0] perm;

    // Byte k = 4*c + r sits at the MSB end of the block.
    always_comb begin
        perm = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                perm[W-1-8*(4*c+r) -: 8] = i_block[W-1-8*(4*src_col(c, r, i_inv)+r) -: 8];
            end
        end
    end

    // Index 0 is the pipeline input; index k+1 is the output of stage k.
    logic [STAGES:0]        vld;
    logic [STAGES:0][W-1:0] dat;
    logic [STAGES:0]        tag;
    logic [STAGES-1:0]      ready;
    logic                   rdy_acc;

    assign vld[0] = i_valid;
    assign dat[0] = perm;
    assign tag[0] = i_inv;

    // A stage can load if it or any stage downstream of it has room, or the sink accepts.
    always_comb begin
        rdy_acc = i_ready;
        ready   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_acc  = rdy_acc || !vld[k+1];
            ready[k] = rdy_acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         valid_q;
        logic [W-1:0] data_q;
        logic         inv_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                inv_q   <= 1'b0;
            end else if (ready[k]) begin
                valid_q <= vld[k];
                data_q  <= dat[k];
                inv_q   <= tag[k];
            end
        end

        assign vld[k+1] = valid_q;
        assign dat[k+1] = data_q;
        assign tag[k+1] = inv_q;
    end

    assign o_ready = ready[0];
    assign o_valid = vld[STAGES];
    assign o_block = dat[STAGES];
    assign o_inv   = tag[STAGES];

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Directed bench for shiftrows_pipe: NB=4/STAGES=1 vector table, NB=6/STAGES=2 latency and
// stall sequence, NB=8/STAGES=3 streaming against a rotate-based model, and mid-flight reset.
module tb_shiftrows_pipe;

    logic clk;
    logic rst;

    logic         a_valid, a_ready, a_inv, a_ovalid, a_iready, a_oinv;
    logic [127:0] a_blk, a_oblk;
    logic         b_valid, b_ready, b_inv, b_ovalid, b_iready, b_oinv;
    logic [191:0] b_blk, b_oblk;
    logic         c_valid, c_ready, c_inv, c_ovalid, c_iready, c_oinv;
    logic [255:0] c_blk, c_oblk;

    int total = 0;
    int bad   = 0;

    shiftrows_pipe #(.NB(4), .STAGES(1)) u_a (
        .clk(clk), .rst(rst), .i_valid(a_valid), .o_ready(a_ready), .i_block(a_blk),
        .i_inv(a_inv), .o_valid(a_ovalid), .i_ready(a_iready), .o_block(a_oblk), .o_inv(a_oinv)
    );

    shiftrows_pipe #(.NB(6), .STAGES(2)) u_b (
        .clk(clk), .rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_block(b_blk),
        .i_inv(b_inv), .o_valid(b_ovalid), .i_ready(b_iready), .o_block(b_oblk), .o_inv(b_oinv)
    );

    shiftrows_pipe #(.NB(8), .STAGES(3)) u_c (
        .clk(clk), .rst(rst), .i_valid(c_valid), .o_ready(c_ready), .i_block(c_blk),
        .i_inv(c_inv), .o_valid(c_ovalid), .i_ready(c_iready), .o_block(c_oblk), .o_inv(c_oinv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent model: pull each row out and rotate it left one byte at a time.
    function automatic logic [255:0] gold8(input logic [255:0] x, input bit inv);
        logic [7:0]   row [8];
        logic [7:0]   tmp;
        logic [255:0] y;
        int           off;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) row[c] = x[255-8*(4*c+r) -: 8];
            off = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 3 : 4;
            if (inv) off = (8 - off) % 8;
            repeat (off) begin
                tmp = row[0];
                for (int c = 0; c < 7; c++) row[c] = row[c+1];
                row[7] = tmp;
            end
            for (int c = 0; c < 8; c++) y[255-8*(4*c+r) -: 8] = row[c];
        end
        return y;
    endfunction

    // Scoreboard for the NB=8 instance; any unexpected output is flagged.
    logic [255:0] exp_blk [$];
    logic         exp_inv [$];

    always @(negedge clk) begin
        if (!rst && c_ovalid && c_iready) begin
            if (exp_blk.size() == 0) begin
                chk("c_unexpected_valid", {255'd0, c_ovalid}, 256'd0);
            end else begin
                chk("c_stream_block", c_oblk, exp_blk.pop_front());
                chk("c_stream_inv", {255'd0, c_oinv}, {255'd0, exp_inv.pop_front()});
            end
        end
    end

    typedef struct {
        string        name;
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [6];

    localparam logic [191:0] CntUp6   = 192'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617;
    localparam logic [191:0] CntUp6F  = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;
    localparam logic [191:0] Plus20   = 192'h20212223_24252627_28292a2b_2c2d2e2f_30313233_34353637;
    localparam logic [191:0] Plus20F  = 192'h20252a2f_24292e33_282d3237_2c313623_30352227_3421262b;
    localparam logic [191:0] CntUp6I  = 192'h0015120f_04011613_08050217_0c090603_100d0a07_14110e0b;

    logic [255:0] x, y;
    int           guard;

    initial begin
        tbl[0] = '{"fwd_rc", 128'h00010203_10111213_20212223_30313233, 1'b0,
                   128'h00112233_10213203_20310213_30011223};
        tbl[1] = '{"inv_rc", 128'h00112233_10213203_20310213_30011223, 1'b1,
                   128'h00010203_10111213_20212223_30313233};
        tbl[2] = '{"fwd_seq", 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0,
                   128'h00050a0f_04090e03_080d0207_0c01060b};
        tbl[3] = '{"inv_seq", 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1,
                   128'h000d0a07_04010e0b_0805020f_0c090603};
        tbl[4] = '{"fwd_ones", {128{1'b1}}, 1'b0, {128{1'b1}}};
        tbl[5] = '{"inv_zero", 128'd0, 1'b1, 128'd0};

        rst = 1'b1;
        {a_valid, a_inv, b_valid, b_inv, c_valid, c_inv} = '0;
        a_blk = '0; b_blk = '0; c_blk = '0;
        {a_iready, b_iready, c_iready} = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", {255'd0, a_ovalid}, 256'd0);
        chk("rst_a_block", {128'd0, a_oblk}, 256'd0);
        chk("rst_b_valid", {255'd0, b_ovalid}, 256'd0);
        chk("rst_b_inv", {255'd0, b_oinv}, 256'd0);
        chk("rst_c_valid", {255'd0, c_ovalid}, 256'd0);
        chk("rst_c_block", c_oblk, 256'd0);
        rst = 1'b0;
        #1;
        chk("rst_a_ready", {255'd0, a_ready}, 256'd1);
        chk("rst_c_ready", {255'd0, c_ready}, 256'd1);

        // NB=4, single stage, back-to-back table.
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1;
            a_blk   = tbl[i].din;
            a_inv   = tbl[i].inv;
            @(posedge clk);
            #1;
            chk({tbl[i].name, "_valid"}, {255'd0, a_ovalid}, 256'd1);
            chk({tbl[i].name, "_block"}, {128'd0, a_oblk}, {128'd0, tbl[i].exp});
            chk({tbl[i].name, "_inv"}, {255'd0, a_oinv}, {255'd0, tbl[i].inv});
        end
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("a_drain_valid", {255'd0, a_ovalid}, 256'd0);

        // NB=6, two stages: two-cycle latency.
        b_valid = 1'b1; b_blk = CntUp6; b_inv = 1'b0;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        chk("b_lat_early", {255'd0, b_ovalid}, 256'd0);
        @(posedge clk);
        #1;
        chk("b_lat_valid", {255'd0, b_ovalid}, 256'd1);
        chk("b_fwd_block", {64'd0, b_oblk}, {64'd0, CntUp6F});
        @(posedge clk);
        #1;

        // Stall: fill with A,B then present C while the sink is blocked.
        b_iready = 1'b0;
        b_valid  = 1'b1; b_blk = CntUp6; b_inv = 1'b0;
        @(posedge clk);
        #1;
        b_blk = Plus20;
        @(posedge clk);
        #1;
        b_blk = CntUp6; b_inv = 1'b1;
        chk("stall_full_ready", {255'd0, b_ready}, 256'd0);
        chk("stall_valid", {255'd0, b_ovalid}, 256'd1);
        chk("stall_block_a", {64'd0, b_oblk}, {64'd0, CntUp6F});
        @(posedge clk);
        #1;
        chk("stall_hold_a", {64'd0, b_oblk}, {64'd0, CntUp6F});
        chk("stall_hold_ready", {255'd0, b_ready}, 256'd0);
        b_iready = 1'b1;
        #1;
        chk("stall_pass_ready", {255'd0, b_ready}, 256'd1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        chk("stall_out_b", {64'd0, b_oblk}, {64'd0, Plus20F});
        chk("stall_out_b_inv", {255'd0, b_oinv}, 256'd0);
        @(posedge clk);
        #1;
        chk("stall_out_c_valid", {255'd0, b_ovalid}, 256'd1);
        chk("stall_out_c", {64'd0, b_oblk}, {64'd0, CntUp6I});
        chk("stall_out_c_inv", {255'd0, b_oinv}, 256'd1);
        @(posedge clk);
        #1;
        chk("stall_empty", {255'd0, b_ovalid}, 256'd0);

        // NB=8, three stages: forward then inverse of the model output, back-to-back.
        for (int i = 0; i < 3; i++) begin
            x = '0;
            for (int w = 0; w < 8; w++) x = {x[223:0], 32'($urandom)};
            y = gold8(x, 1'b0);
            exp_blk.push_back(y); exp_inv.push_back(1'b0);
            exp_blk.push_back(x); exp_inv.push_back(1'b1);
            c_valid = 1'b1; c_blk = x; c_inv = 1'b0;
            @(posedge clk);
            #1;
            c_blk = y; c_inv = 1'b1;
            @(posedge clk);
            #1;
        end
        c_valid = 1'b0;
        guard   = 0;
        while (exp_blk.size() != 0 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("c_stream_drained", 256'(exp_blk.size()), 256'd0);

        // Mid-flight reset: two blocks inside, neither may ever emerge.
        c_valid = 1'b1; c_blk = {8{32'hdeadbeef}}; c_inv = 1'b0;
        @(posedge clk);
        #1;
        c_blk = {8{32'h01234567}}; c_inv = 1'b1;
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_valid", {255'd0, c_ovalid}, 256'd0);
        chk("rst_mid_block", c_oblk, 256'd0);
        #1;
        chk("rst_mid_ready", {255'd0, c_ready}, 256'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("rst_mid_no_emit", {255'd0, c_ovalid}, 256'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
